// File: rtl/mem_test_initiator.sv
// Self-test master for a single-port memory: writes pattern^addr to every word,
// reads each back, and reports pass/fail, error count and the first failing address.
module mem_test_initiator #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDRESS    = 4,
  parameter int RD_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   pattern,
  output logic               wr_en,
  output logic               rd_en,
  output logic [ADDRESS-1:0] address,
  output logic [WIDTH-1:0]   in_data,
  input  logic [WIDTH-1:0]   out_data,
  input  logic               valid_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ADDRESS:0]   err_count,
  output logic [ADDRESS-1:0] first_err_addr,
  output logic               timeout_seen
);

  localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  localparam logic [ADDRESS:0] CNT_ONE  = (ADDRESS+1)'(1);
  localparam logic [ADDRESS:0] CNT_LAST = (ADDRESS+1)'(DEPTH - 1);
  localparam logic [ADDRESS:0] CNT_END  = (ADDRESS+1)'(DEPTH);
  localparam logic [TW-1:0]    TMR_ONE  = TW'(1);
  localparam logic [TW-1:0]    TMR_LAST = TW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDRESS:0]   cnt;
  logic [ADDRESS:0]   cnt_nxt;
  logic [ADDRESS:0]   cnt_plus;
  logic [TW-1:0]      timer;
  logic [TW-1:0]      timer_nxt;
  logic [WIDTH-1:0]   pattern_q;
  logic [WIDTH-1:0]   pattern_nxt;
  logic               wr_en_nxt;
  logic               rd_en_nxt;
  logic [ADDRESS-1:0] address_nxt;
  logic [WIDTH-1:0]   in_data_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic               pass_nxt;
  logic [ADDRESS:0]   err_nxt;
  logic [ADDRESS-1:0] first_nxt;
  logic               tos_nxt;
  logic               resolve;
  logic               is_err;

  function automatic logic [WIDTH-1:0] exp_data(input logic [WIDTH-1:0] base,
                                                input logic [ADDRESS-1:0] a);
    exp_data = base ^ {{(WIDTH-ADDRESS){1'b0}}, a};
  endfunction

  assign cnt_plus = cnt + CNT_ONE;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and next value of every register; the bus command for the
  // following cycle is decided here, so a read response retires on the same
  // edge that launches the next read
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    timer_nxt   = timer;
    pattern_nxt = pattern_q;
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    address_nxt = address;
    in_data_nxt = in_data;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    pass_nxt    = pass;
    err_nxt     = err_count;
    first_nxt   = first_err_addr;
    tos_nxt     = timeout_seen;
    resolve     = 1'b0;
    is_err      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          pattern_nxt = pattern;
          err_nxt     = '0;
          first_nxt   = '0;
          pass_nxt    = 1'b0;
          tos_nxt     = 1'b0;
          busy_nxt    = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = S_WRITE;
        end else begin
          state_nxt = S_IDLE;
        end
      end

      S_WRITE: begin
        if (cnt == CNT_END) begin
          rd_en_nxt   = 1'b1;
          address_nxt = '0;
          cnt_nxt     = '0;
          state_nxt   = S_RD_REQ;
        end else begin
          wr_en_nxt   = 1'b1;
          address_nxt = cnt[ADDRESS-1:0];
          in_data_nxt = exp_data(pattern_q, cnt[ADDRESS-1:0]);
          cnt_nxt     = cnt_plus;
        end
      end

      S_RD_REQ: begin
        timer_nxt = '0;
        state_nxt = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        // a response in the final wait cycle still counts as data
        if (valid_out) begin
          resolve = 1'b1;
          is_err  = (out_data != exp_data(pattern_q, cnt[ADDRESS-1:0]));
        end else if (timer == TMR_LAST) begin
          resolve = 1'b1;
          is_err  = 1'b1;
          tos_nxt = 1'b1;
        end else begin
          timer_nxt = timer + TMR_ONE;
        end

        if (resolve && is_err) begin
          err_nxt = err_count + CNT_ONE;
          if (err_count == '0) begin
            first_nxt = cnt[ADDRESS-1:0];
          end else begin
            first_nxt = first_err_addr;
          end
        end else begin
          err_nxt = err_count;
        end

        if (resolve) begin
          if (cnt == CNT_LAST) begin
            state_nxt = S_FIN;
          end else begin
            cnt_nxt     = cnt_plus;
            rd_en_nxt   = 1'b1;
            address_nxt = cnt_plus[ADDRESS-1:0];
            state_nxt   = S_RD_REQ;
          end
        end else begin
          state_nxt = S_RD_WAIT;
        end
      end

      S_FIN: begin
        done_nxt  = 1'b1;
        pass_nxt  = (err_count == '0);
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      timer          <= '0;
      pattern_q      <= '0;
      wr_en          <= 1'b0;
      rd_en          <= 1'b0;
      address        <= '0;
      in_data        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      timeout_seen   <= 1'b0;
    end else begin
      cnt            <= cnt_nxt;
      timer          <= timer_nxt;
      pattern_q      <= pattern_nxt;
      wr_en          <= wr_en_nxt;
      rd_en          <= rd_en_nxt;
      address        <= address_nxt;
      in_data        <= in_data_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      pass           <= pass_nxt;
      err_count      <= err_nxt;
      first_err_addr <= first_nxt;
      timeout_seen   <= tos_nxt;
    end
  end

endmodule
